hazard_intr_ctrl: RTL

Pipeline control unit that drives the flush and stall inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, including ID/EX's Cancel_ID.
- Detects load-use hazards and inserts bubbles.
- Redirects the PC on EX-stage taken branches.
- Sequences interrupt entry and eret return: captures EPC from the ID/EX pc output and owns the interrupt-enable flag.
- Sits beside the hazard/forwarding logic; all stage registers consume its outputs.

---
 rtl/hazard_intr_ctrl_pkg.sv | 31 +++
 rtl/hazard_intr_ctrl_sync.sv | 43 ++++
 rtl/hazard_intr_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_intr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_intr_ctrl_pkg
// Shared constants and types for the pipeline hazard / interrupt controller:
//   - pc_sel encodings (sequential, branch, handler, epc)
//   - FSM state type (IDLE, PEND, HANDLER)
//   - bubble PC marker and default interrupt handler address
//   - saturating 16-bit increment used by the optional event counters
// -----------------------------------------------------------------------------
package hazard_intr_ctrl_pkg;

   localparam logic [1:0] PC_SEL_SEQ     = 2'd0;
   localparam logic [1:0] PC_SEL_BR      = 2'd1;
   localparam logic [1:0] PC_SEL_HANDLER = 2'd2;
   localparam logic [1:0] PC_SEL_EPC     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PEND    = 2'd1,
      ST_HANDLER = 2'd2
   } state_t;

   // A pc of zero in ID/EX marks a bubble: there is no real instruction to
   // attach an EPC to, so an interrupt cannot be taken on it.
   localparam logic [31:0] BUBBLE_PC            = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0004;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/hazard_intr_ctrl_sync.sv
// -----------------------------------------------------------------------------
// intr_sync
// N-flop synchronizer for an asynchronous level input.
//   clk   : clock
//   rst   : asynchronous active-high reset (clears all flops)
//   d     : asynchronous input
//   q     : synchronized output, STAGES edges after d
// STAGES below 2 is raised to 2; a single flop does not give enough
// metastability settling time.
// -----------------------------------------------------------------------------
module intr_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   localparam int N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] sync_reg;
   logic [N-1:0] sync_next;

   assign sync_next[0] = d;

   generate
      for (genvar gi = 1; gi < N; gi++) begin : g_shift
         assign sync_next[gi] = sync_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= sync_next;
      end
   end

   assign q = sync_reg[N-1];

endmodule

// File: rtl/hazard_intr_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_intr_ctrl
// Pipeline control unit: load-use stalls, EX-stage branch redirect, interrupt
// entry (EPC capture from ID/EX pc) and eret return.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   id_rs, id_rt       ID source registers (bit5 set = c0 register)
//   id_uses_rt         ID instruction reads rt
//   id_eret            ID instruction is eret
//   ex_memread         EX instruction is a load
//   ex_wr_reg          EX destination register
//   ex_pc              ID/EX pc (0 = bubble)
//   ex_branch_taken    branch/jump resolved taken in EX
//   ex_branch_target   branch target
//   intr_req           asynchronous level interrupt request
//   stall_pc           hold PC
//   stall_if_id        hold IF/ID
//   cancel_if/id/ex    flush IF/ID, ID/EX, EX/MEM
//   pc_sel             0 seq, 1 branch, 2 handler, 3 epc
//   pc_redirect        redirect address (0 when pc_sel is 0)
//   intr_ack           one-cycle pulse when an interrupt is taken
//   epc_o, ie_o        saved exception PC and interrupt enable (registered)
//   state_o            FSM state (debug)
//   stall_cnt/flush_cnt  saturating event counters, present only when
//                        HAZARD_STALL_CNT_EN is defined
// -----------------------------------------------------------------------------
module hazard_intr_ctrl
   import hazard_intr_ctrl_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  id_rs,
   input  logic [5:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_eret,
   input  logic        ex_memread,
   input  logic [5:0]  ex_wr_reg,
   input  logic [31:0] ex_pc,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_branch_target,
   input  logic        intr_req,
   output logic        stall_pc,
   output logic        stall_if_id,
   output logic        cancel_if,
   output logic        cancel_id,
   output logic        cancel_ex,
   output logic [1:0]  pc_sel,
   output logic [31:0] pc_redirect,
   output logic        intr_ack,
   output logic [31:0] epc_o,
   output logic        ie_o,
`ifdef HAZARD_STALL_CNT_EN
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
`endif
   output logic [1:0]  state_o
);

   state_t      state_reg;
   logic [31:0] epc_reg;
   logic        ie_reg;

   logic intr_s;
   logic lu;
   logic br;
   logic take;
   logic eret_go;

   intr_sync #(
      .STAGES(SYNC_STAGES)
   ) u_intr_sync (
      .clk (clk),
      .rst (rst),
      .d   (intr_req),
      .q   (intr_s)
   );

   // Register 0 is never a real dependency, so a load to it cannot stall.
   assign lu = ex_memread && (ex_wr_reg != 6'd0) &&
               ((ex_wr_reg == id_rs) || (id_uses_rt && (ex_wr_reg == id_rt)));
   assign br = ex_branch_taken;

   // An interrupt waits for a real instruction in EX that is not itself
   // being squashed by a branch, so the EPC is always a valid restart point.
   assign take = (state_reg == ST_PEND) && (ex_pc != BUBBLE_PC) && !br;

   // eret on a branch shadow is wrong-path; eret behind a load-use waits.
   assign eret_go = (state_reg == ST_HANDLER) && id_eret && !br && !lu;

   always_comb begin
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      cancel_if   = 1'b0;
      cancel_id   = 1'b0;
      cancel_ex   = 1'b0;
      pc_sel      = PC_SEL_SEQ;
      pc_redirect = 32'h0;
      intr_ack    = 1'b0;
      if (!rst) begin
         if (take) begin
            cancel_if   = 1'b1;
            cancel_id   = 1'b1;
            cancel_ex   = 1'b1;
            pc_sel      = PC_SEL_HANDLER;
            pc_redirect = HANDLER_ADDR;
            intr_ack    = 1'b1;
         end else if (br) begin
            cancel_if   = 1'b1;
            cancel_id   = 1'b1;
            pc_sel      = PC_SEL_BR;
            pc_redirect = ex_branch_target;
         end else if (eret_go) begin
            cancel_if   = 1'b1;
            pc_sel      = PC_SEL_EPC;
            pc_redirect = epc_reg;
         end else if (lu) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            cancel_id   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         epc_reg   <= 32'h0;
         ie_reg    <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               ie_reg <= 1'b1;
               if (intr_s) begin
                  state_reg <= ST_PEND;
               end
            end
            // Once pending, the interrupt is committed even if the request
            // line drops again.
            ST_PEND: begin
               if (take) begin
                  epc_reg   <= ex_pc;
                  ie_reg    <= 1'b0;
                  state_reg <= ST_HANDLER;
               end
            end
            ST_HANDLER: begin
               if (eret_go) begin
                  ie_reg    <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign epc_o   = epc_reg;
   assign ie_o    = ie_reg;
   assign state_o = state_reg;

`ifdef HAZARD_STALL_CNT_EN
   logic [15:0] stall_cnt_reg;
   logic [15:0] flush_cnt_reg;

   // stall_pc is asserted exactly in the cycles where a load-use is acted on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_reg <= 16'h0;
         flush_cnt_reg <= 16'h0;
      end else begin
         if (stall_pc) begin
            stall_cnt_reg <= sat_inc16(stall_cnt_reg);
         end
         if (pc_sel != PC_SEL_SEQ) begin
            flush_cnt_reg <= sat_inc16(flush_cnt_reg);
         end
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
`endif

endmodule
